alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: none; register file fixed at 8 x 32 bits, r0 hardwired to zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 hold  input  1  freeze: no stage advances while high.
REQ-005 in_valid  input  1  command present.
REQ-006 in_ready  output  1  command accepted on edge where in_valid && in_ready.
REQ-007 in_op  input  3  ALU opcode forwarded unchanged to alu_op.
REQ-008 in_rd / in_rs / in_rt  input  3 each  destination / source A / source B register indices.
REQ-009 in_useimm  input  1  select immediate instead of rt for operand B.
REQ-010 in_imm  input  16  immediate, zero-extended to 32 bits.
REQ-011 alu_A / alu_B  output  32 each  registered operands to downstream ALU.
REQ-012 alu_op  output  3  registered opcode to downstream ALU.
REQ-013 alu_C  input  32  combinational ALU result for current alu_A/alu_B/alu_op.
REQ-014 wb_valid  output  1  one-cycle pulse per retired command.
REQ-015 wb_rd  output  3  destination of retired command.
REQ-016 wb_data  output  32  result of retired command.
REQ-017 dbg_addr  input  3  debug read index; dbg_data  output  32  combinational regfile[dbg_addr] (0 for index 0).
REQ-018 retire_cnt  output  32  count of retired commands.

Function
REQ-019 in_ready SHALL equal !reset && !hold (combinational).
REQ-020 Issue stage: on accept edge, SHALL load iss_valid=1, alu_op=in_op, iss_rd=in_rd, alu_A=srcA, alu_B=in_useimm ? {16'b0,in_imm} : srcB.
REQ-021 When hold=0 and no accept, iss_valid SHALL clear to 0; alu_A/alu_B/alu_op SHALL retain previous values.
REQ-022 Operand read: index 0 SHALL yield 0; if index == iss_rd, iss_valid=1, iss_rd!=0, SHALL yield alu_C (forward); else regfile[index].
REQ-023 Writeback: on edge with hold=0, wb_valid<=iss_valid, wb_rd<=iss_rd, wb_data<=alu_C when iss_valid, else wb_data unchanged.
REQ-024 Same edge: if iss_valid && iss_rd!=0, regfile[iss_rd]<=alu_C; writes to r0 SHALL be discarded but still retire with wb_valid=1.
REQ-025 retire_cnt SHALL increment by 1 on each edge where hold=0 && iss_valid, wrapping 32'hFFFFFFFF -> 0.
REQ-026 Latency: command accepted at edge N presents operands in cycle N+1, retires (wb_valid=1, regfile updated) at edge N+1, visible on dbg_data from cycle N+2.
REQ-027 Throughput: one command per cycle back-to-back, no stall for any dependency.
REQ-028 hold=1: issue registers, wb registers, regfile, retire_cnt SHALL all hold; wb_valid SHALL hold its value; no command accepted.
REQ-029 Opcodes 110/111 SHALL pass through unmodified; the returned alu_C (0 from the ALU) is written back normally.
REQ-030 rs==rt==iss_rd SHALL forward alu_C to both operands.

Reset
REQ-031 On edge with reset=1 (overrides hold and in_valid): iss_valid=0, alu_A=0, alu_B=0, alu_op=0, iss_rd=0, wb_valid=0, wb_rd=0, wb_data=0, retire_cnt=0, all regfile entries 0.
REQ-032 Reset mid-operation SHALL discard in-flight commands with no regfile write and no wb_valid pulse.

Verification
REQ-033 After reset, accept {op=000, rd=1, rs=0, useimm=1, imm=0x0005} -> cycle+1 alu_A=0, alu_B=5; next edge wb_valid=1, wb_rd=1, wb_data=5, dbg r1=5, retire_cnt=1.
REQ-034 Back-to-back r1=5 then {op=000, rd=2, rs=1, useimm=1, imm=3} -> second command alu_A=5 via forward; r2=8; retire_cnt=2.
REQ-035 r2=8, r1=5: {op=001, rd=3, rs=1, rt=2} -> r3=0xFFFFFFFD; {op=101, rd=4, rs=3, useimm=1, imm=1} with signed-shift ALU -> r4=0xFFFFFFFE.
REQ-036 Command with rd=0 and imm=0xFFFF -> wb_valid=1, wb_rd=0, wb_data=0x0000FFFF; dbg r0 stays 0.
REQ-037 hold=1 for 3 cycles with command in issue stage -> in_ready=0, wb_valid and retire_cnt frozen; release -> command retires exactly once.
REQ-038 Assert reset one cycle after accept -> no wb_valid pulse, regfile all 0, retire_cnt=0, in_ready=0 during reset.

Source files
------------

// File: rtl/alu_issue_if.sv
// Command, ALU-operand and writeback signals shared between alu_issue and its environment.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic        in_useimm;
  logic [15:0] in_imm;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_op;
  logic [31:0] alu_C;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_useimm, in_imm, alu_C,
    output in_ready, alu_A, alu_B, alu_op, wb_valid, wb_rd, wb_data
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_useimm, in_imm, alu_C,
    input  in_ready, alu_A, alu_B, alu_op, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/alu_issue.sv
// Two-stage issue/writeback front end for an external ALU with an 8 x 32 register file
// (r0 reads as zero) and full forwarding of the in-flight result.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  alu_issue_if.slave  bus,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] retire_cnt
);

  logic        iss_valid_q, iss_valid_d;
  logic [2:0]  iss_rd_q,    iss_rd_d;
  logic [31:0] alu_a_q,     alu_a_d;
  logic [31:0] alu_b_q,     alu_b_d;
  logic [2:0]  alu_op_q,    alu_op_d;
  logic        wb_valid_q,  wb_valid_d;
  logic [2:0]  wb_rd_q,     wb_rd_d;
  logic [31:0] wb_data_q,   wb_data_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] regs_q [8];
  logic [31:0] regs_d [8];

  logic        accept;
  logic [31:0] src_a;
  logic [31:0] src_b;

  assign bus.in_ready = !reset && !hold;
  assign accept       = bus.in_valid && bus.in_ready;

  // regs_q[0] is never written, so a plain lookup already returns 0 for r0.
  always_comb begin
    src_a = regs_q[bus.in_rs];
    if (iss_valid_q && (iss_rd_q != 3'd0) && (bus.in_rs == iss_rd_q)) begin
      src_a = bus.alu_C;
    end
    src_b = regs_q[bus.in_rt];
    if (iss_valid_q && (iss_rd_q != 3'd0) && (bus.in_rt == iss_rd_q)) begin
      src_b = bus.alu_C;
    end
  end

  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_rd_d     = iss_rd_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    retire_cnt_d = retire_cnt_q;
    regs_d       = regs_q;
    if (!hold) begin
      iss_valid_d = accept;
      if (accept) begin
        iss_rd_d = bus.in_rd;
        alu_op_d = bus.in_op;
        alu_a_d  = src_a;
        alu_b_d  = bus.in_useimm ? {16'b0, bus.in_imm} : src_b;
      end
      wb_valid_d = iss_valid_q;
      wb_rd_d    = iss_rd_q;
      if (iss_valid_q) begin
        wb_data_d    = bus.alu_C;
        retire_cnt_d = retire_cnt_q + 32'd1;
        if (iss_rd_q != 3'd0) begin
          regs_d[iss_rd_q] = bus.alu_C;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid_q  <= 1'b0;
      iss_rd_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_rd_q     <= iss_rd_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      retire_cnt_q <= retire_cnt_d;
      regs_q       <= regs_d;
    end
  end

  assign bus.alu_A    = alu_a_q;
  assign bus.alu_B    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign retire_cnt   = retire_cnt_q;
  assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue: an in-order architectural model predicts
// operands, writebacks, retire count and committed register contents.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] retire_cnt;

  alu_issue_if bus ();

  alu_issue dut (
    .clk        (clk),
    .reset      (rst),
    .hold       (hold),
    .bus        (bus),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Downstream ALU: add, sub, and, or, xor, arithmetic right shift; 110/111 yield 0.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_C = alu_ref(bus.alu_op, bus.alu_A, bus.alu_B);

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
  } ret_t;

  ret_t        pend[$];
  logic [31:0] arch_rf [8];
  logic [31:0] comm_rf [8];
  logic        m_wbv;
  logic [2:0]  m_wbrd;
  logic [31:0] m_wbd;
  logic [31:0] m_cnt;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_op;
  logic [2:0]  m_issrd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 8; i++) begin
      arch_rf[i] = '0;
      comm_rf[i] = '0;
    end
    m_wbv = 1'b0; m_wbrd = '0; m_wbd = '0; m_cnt = '0;
    m_a = '0; m_b = '0; m_op = '0; m_issrd = '0;
  endtask

  // Commands execute architecturally at acceptance; the DUT shows the result one edge later.
  task automatic model_edge();
    ret_t        e;
    logic [31:0] a;
    logic [31:0] b;
    if (rst) begin
      model_reset();
    end else if (!hold) begin
      if (pend.size() > 0) begin
        e = pend.pop_front();
        m_wbv = 1'b1; m_wbrd = e.rd; m_wbd = e.data; m_cnt = m_cnt + 32'd1;
        if (e.rd != 3'd0) comm_rf[e.rd] = e.data;
      end else begin
        m_wbv = 1'b0; m_wbrd = m_issrd;
      end
      if (bus.in_valid) begin
        a = arch_rf[bus.in_rs];
        b = bus.in_useimm ? {16'h0, bus.in_imm} : arch_rf[bus.in_rt];
        e.rd = bus.in_rd;
        e.data = alu_ref(bus.in_op, a, b);
        if (bus.in_rd != 3'd0) arch_rf[bus.in_rd] = e.data;
        pend.push_back(e);
        m_a = a; m_b = b; m_op = bus.in_op; m_issrd = bus.in_rd;
      end
    end
  endtask

  task automatic check_all();
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, !rst && !hold});
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_wbv});
    check("wb_rd", {29'd0, bus.wb_rd}, {29'd0, m_wbrd});
    check("wb_data", bus.wb_data, m_wbd);
    check("retire_cnt", retire_cnt, m_cnt);
    check("alu_A", bus.alu_A, m_a);
    check("alu_B", bus.alu_B, m_b);
    check("alu_op", {29'd0, bus.alu_op}, {29'd0, m_op});
    check("dbg_data", dbg_data, comm_rf[dbg_addr]);
  endtask

  task automatic cyc(input logic r, input logic h, input logic v, input logic [2:0] op,
                     input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                     input logic ui, input logic [15:0] imm, input logic [2:0] da);
    @(negedge clk);
    rst = r; hold = h; dbg_addr = da;
    bus.in_valid = v; bus.in_op = op; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_useimm = ui; bus.in_imm = imm;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input logic [2:0] da);
    cyc(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, da);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; dbg_addr = '0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_useimm = 1'b0; bus.in_imm = '0;
    model_reset();

    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 3'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);

    // r1 = 0 + 5
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 3'd1);
    check("first_A", bus.alu_A, 32'd0);
    check("first_B", bus.alu_B, 32'd5);
    idle(3'd1);
    check("first_wb", bus.wb_data, 32'd5);
    check("first_r1", dbg_data, 32'd5);
    check("first_cnt", retire_cnt, 32'd1);

    // Back-to-back dependency: r1 = 5, then r2 = r1 + 3 via forwarding
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 3'd1);
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0003, 3'd1);
    check("fwd_A", bus.alu_A, 32'd5);
    idle(3'd2);
    check("fwd_r2", dbg_data, 32'd8);

    // r3 = r1 - r2, then r4 = r3 >>> 1 forwarded
    cyc(1'b0, 1'b0, 1'b1, 3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd0);
    cyc(1'b0, 1'b0, 1'b1, 3'b101, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0001, 3'd3);
    check("sub_r3", dbg_data, 32'hFFFF_FFFD);
    idle(3'd4);
    check("sra_r4", dbg_data, 32'hFFFF_FFFE);

    // Write to r0 retires but is discarded
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 3'd0);
    idle(3'd0);
    check("r0_wb_data", bus.wb_data, 32'h0000_FFFF);
    check("r0_dbg", dbg_data, 32'd0);

    // Freeze with a command in the issue stage
    cyc(1'b0, 1'b0, 1'b1, 3'b011, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 3'b000, 3'd6, 3'd1, 3'd1, 1'b0, 16'h0000, 3'd5);
    end
    idle(3'd5);
    check("hold_r5", dbg_data, 32'd13);
    idle(3'd5);

    // Reset one cycle after acceptance
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'd6, 3'd2, 3'd0, 1'b1, 16'h0010, 3'd0);
    cyc(1'b1, 1'b0, 1'b1, 3'b000, 3'd7, 3'd2, 3'd0, 1'b1, 16'h0010, 3'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      check("rst_rf", dbg_data, 32'd0);
      check("rst_cnt", retire_cnt, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 3'($urandom),
          3'($urandom), 1'($urandom), 16'($urandom), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
